// File: rtl/pe_job_dispatcher.sv
// Host-side initiator for one PE: serialises a job into filter/spike/psum/start packets, then collects the psum result.
// Optional macro FILTER_REUSE_EN skips the filter packet when the filter matches the last one transferred.
module pe_job_dispatcher #(
    parameter int PE_IDX         = 1,
    parameter int SELF_ADDR      = 0,
    parameter int ADDR_WIDTH     = 4,
    parameter int OP_WIDTH       = 2,
    parameter int DATA_WIDTH     = 24,
    parameter int PACKET_WIDTH   = 34,
    parameter int SPIKE_WIDTH    = 5,
    parameter int PSUM_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    input  logic [DATA_WIDTH-1:0]   job_filter_i,
    input  logic [SPIKE_WIDTH-1:0]  job_spike_i,
    input  logic [PSUM_WIDTH-1:0]   job_psum_i,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic [PACKET_WIDTH-1:0] tx_packet_o,
    input  logic                    rx_valid_i,
    output logic                    rx_ready_o,
    input  logic [PACKET_WIDTH-1:0] rx_packet_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [PSUM_WIDTH-1:0]   res_psum_o,
    output logic                    busy_o,
    output logic                    err_timeout_o,
    output logic                    err_drop_o
);

    localparam logic [OP_WIDTH-1:0]   OP_FILTER = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0]   OP_SPIKE  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0]   OP_PSUM   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0]   OP_START  = OP_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] DEST_ADDR = ADDR_WIDTH'(PE_IDX);
    localparam logic [ADDR_WIDTH-1:0] SRC_ADDR  = ADDR_WIDTH'(SELF_ADDR);

    localparam int                    CNT_WIDTH    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0]  TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_F,
        SEND_S,
        SEND_P,
        SEND_GO,
        WAIT_RES,
        HOLD_RES
    } state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0]  filter_q, filter_d;
    logic [SPIKE_WIDTH-1:0] spike_q, spike_d;
    logic [PSUM_WIDTH-1:0]  psum_q, psum_d;
    logic [PSUM_WIDTH-1:0]  res_psum_q, res_psum_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   err_timeout_q, err_timeout_d;
    logic                   err_drop_q, err_drop_d;

    logic [ADDR_WIDTH-1:0]  rx_src;
    logic [OP_WIDTH-1:0]    rx_op;
    logic                   rx_fire;
    logic                   rx_result;
    logic                   rx_drop;
    logic                   timeout_hit;
    logic                   filter_hit;
    logic                   rx_unused;

    logic [OP_WIDTH-1:0]    tx_op;
    logic [DATA_WIDTH-1:0]  tx_data;

    assign rx_src    = rx_packet_i[PACKET_WIDTH-ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign rx_op     = rx_packet_i[DATA_WIDTH+OP_WIDTH-1 -: OP_WIDTH];
    assign rx_unused = ^{rx_packet_i[PACKET_WIDTH-1 -: ADDR_WIDTH], rx_packet_i[DATA_WIDTH-1:PSUM_WIDTH]};

    // Op 11 is the PE's done notice: consumed without raising a drop error.
    assign rx_fire     = rx_valid_i && (state_q == WAIT_RES);
    assign rx_result   = rx_fire && (rx_src == DEST_ADDR) && (rx_op == OP_PSUM);
    assign rx_drop     = rx_fire && !rx_result && (rx_op != OP_START);
    assign timeout_hit = (state_q == WAIT_RES) && !rx_result && (cnt_q == TIMEOUT_LAST);

`ifdef FILTER_REUSE_EN
    logic [DATA_WIDTH-1:0] last_filter_q, last_filter_d;
    logic                  last_valid_q, last_valid_d;

    always_comb begin
        last_filter_d = last_filter_q;
        last_valid_d  = last_valid_q;
        if ((state_q == SEND_F) && tx_ready_i) begin
            last_filter_d = filter_q;
            last_valid_d  = 1'b1;
        end
        if (timeout_hit) begin
            last_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_filter_q <= '0;
            last_valid_q  <= 1'b0;
        end else begin
            last_filter_q <= last_filter_d;
            last_valid_q  <= last_valid_d;
        end
    end

    assign filter_hit = last_valid_q && (job_filter_i == last_filter_q);
`else
    assign filter_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (job_valid_i) state_d = filter_hit ? SEND_S : SEND_F;
            SEND_F:   if (tx_ready_i) state_d = SEND_S;
            SEND_S:   if (tx_ready_i) state_d = SEND_P;
            SEND_P:   if (tx_ready_i) state_d = SEND_GO;
            SEND_GO:  if (tx_ready_i) state_d = WAIT_RES;
            WAIT_RES: begin
                // A result in the final cycle still wins over the timeout.
                if (rx_result) begin
                    state_d = HOLD_RES;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            HOLD_RES: if (res_ready_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        job_ready_o = 1'b0;
        busy_o      = 1'b1;
        tx_valid_o  = 1'b0;
        rx_ready_o  = 1'b0;
        res_valid_o = 1'b0;
        tx_op       = OP_FILTER;
        tx_data     = '0;
        case (state_q)
            IDLE: begin
                job_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            SEND_F: begin
                tx_valid_o = 1'b1;
                tx_op      = OP_FILTER;
                tx_data    = filter_q;
            end
            SEND_S: begin
                tx_valid_o = 1'b1;
                tx_op      = OP_SPIKE;
                tx_data    = DATA_WIDTH'(spike_q);
            end
            SEND_P: begin
                tx_valid_o = 1'b1;
                tx_op      = OP_PSUM;
                tx_data    = DATA_WIDTH'(psum_q);
            end
            SEND_GO: begin
                tx_valid_o = 1'b1;
                tx_op      = OP_START;
                tx_data    = '0;
            end
            WAIT_RES: rx_ready_o  = 1'b1;
            HOLD_RES: res_valid_o = 1'b1;
            default: begin
                job_ready_o = 1'b0;
            end
        endcase
        tx_packet_o = tx_valid_o ? {DEST_ADDR, SRC_ADDR, tx_op, tx_data} : '0;
    end

    always_comb begin
        filter_d      = filter_q;
        spike_d       = spike_q;
        psum_d        = psum_q;
        res_psum_d    = res_psum_q;
        err_drop_d    = rx_drop;
        err_timeout_d = timeout_hit;
        if ((state_q == IDLE) && job_valid_i) begin
            filter_d = job_filter_i;
            spike_d  = job_spike_i;
            psum_d   = job_psum_i;
        end
        if (rx_result) begin
            res_psum_d = rx_packet_i[PSUM_WIDTH-1:0];
        end
        // Counter runs only while staying in WAIT_RES, so it is zero on every entry.
        cnt_d = ((state_q == WAIT_RES) && (state_d == WAIT_RES)) ? cnt_q + CNT_WIDTH'(1) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            filter_q      <= '0;
            spike_q       <= '0;
            psum_q        <= '0;
            res_psum_q    <= '0;
            cnt_q         <= '0;
            err_timeout_q <= 1'b0;
            err_drop_q    <= 1'b0;
        end else begin
            filter_q      <= filter_d;
            spike_q       <= spike_d;
            psum_q        <= psum_d;
            res_psum_q    <= res_psum_d;
            cnt_q         <= cnt_d;
            err_timeout_q <= err_timeout_d;
            err_drop_q    <= err_drop_d;
        end
    end

    assign res_psum_o    = res_psum_q;
    assign err_timeout_o = err_timeout_q;
    assign err_drop_o    = err_drop_q;

endmodule

// File: tb/tb_pe_job_dispatcher.sv
// Directed self-checking bench for pe_job_dispatcher, run with an 8-cycle result timeout.
module tb_pe_job_dispatcher;

    logic        clk;
    logic        reset;
    logic        jobValid;
    logic        jobReady;
    logic [23:0] jobFilter;
    logic [4:0]  jobSpike;
    logic [7:0]  jobPsum;
    logic        txValid;
    logic        txReady;
    logic [33:0] txPacket;
    logic        rxValid;
    logic        rxReady;
    logic [33:0] rxPacket;
    logic        resValid;
    logic        resReady;
    logic [7:0]  resPsum;
    logic        busy;
    logic        errTimeout;
    logic        errDrop;

    int total = 0;
    int bad   = 0;

    pe_job_dispatcher #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .job_valid_i  (jobValid),
        .job_ready_o  (jobReady),
        .job_filter_i (jobFilter),
        .job_spike_i  (jobSpike),
        .job_psum_i   (jobPsum),
        .tx_valid_o   (txValid),
        .tx_ready_i   (txReady),
        .tx_packet_o  (txPacket),
        .rx_valid_i   (rxValid),
        .rx_ready_o   (rxReady),
        .rx_packet_i  (rxPacket),
        .res_valid_o  (resValid),
        .res_ready_i  (resReady),
        .res_psum_o   (resPsum),
        .busy_o       (busy),
        .err_timeout_o(errTimeout),
        .err_drop_o   (errDrop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a job for exactly one accepting edge.
    task automatic start_job(input logic [23:0] f, input logic [4:0] s, input logic [7:0] p);
        jobFilter = f;
        jobSpike  = s;
        jobPsum   = p;
        jobValid  = 1'b1;
        tick();
        jobValid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({jobReady, busy, txValid, rxReady, resValid, errTimeout, errDrop} !== 7'b1000000) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b expected %b",
                     {jobReady, busy, txValid, rxReady, resValid, errTimeout, errDrop}, 7'b1000000);
        end
        total++;
        if (txPacket !== 34'h0) begin
            bad++;
            $display("[TB] FAIL reset_tx_packet: got %h expected %h", txPacket, 34'h0);
        end
        total++;
        if (resPsum !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_res_psum: got %h expected %h", resPsum, 8'h00);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_job();
        logic [33:0] expPkt [4];
        expPkt[0] = 34'h040030201;
        expPkt[1] = 34'h041000016;
        expPkt[2] = 34'h042000005;
        expPkt[3] = 34'h043000000;
        txReady = 1'b1;
        total++;
        if (jobReady !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_job_ready: got %b expected %b", jobReady, 1'b1);
        end
        start_job(24'h030201, 5'b10110, 8'h05);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({txValid, busy, txPacket} !== {1'b1, 1'b1, expPkt[i]}) begin
                bad++;
                $display("[TB] FAIL basic_pkt%0d: got valid=%b busy=%b pkt=%h expected valid=1 busy=1 pkt=%h",
                         i, txValid, busy, txPacket, expPkt[i]);
            end
            tick();
        end
        total++;
        if ({rxReady, txValid} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL basic_wait_res: got rx_ready,tx_valid=%b expected %b", {rxReady, txValid}, 2'b10);
        end
        rxValid  = 1'b1;
        rxPacket = 34'h00600000C;
        tick();
        rxValid = 1'b0;
        total++;
        if ({resValid, resPsum, rxReady} !== {1'b1, 8'h0C, 1'b0}) begin
            bad++;
            $display("[TB] FAIL basic_result: got valid=%b psum=%h rx_ready=%b expected valid=1 psum=0c rx_ready=0",
                     resValid, resPsum, rxReady);
        end
        tick();
        total++;
        if ({resValid, resPsum} !== {1'b1, 8'h0C}) begin
            bad++;
            $display("[TB] FAIL basic_result_hold: got valid=%b psum=%h expected valid=1 psum=0c", resValid, resPsum);
        end
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
        total++;
        if ({jobReady, resValid, busy} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL basic_back_to_idle: got %b expected %b", {jobReady, resValid, busy}, 3'b100);
        end
    endtask

    task automatic test_stall_and_drop();
        txReady = 1'b1;
        start_job(24'h0ABCDE, 5'h03, 8'h7F);
        tick();
        txReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({txValid, txPacket} !== {1'b1, 34'h041000003}) begin
                bad++;
                $display("[TB] FAIL stall_cycle%0d: got valid=%b pkt=%h expected valid=1 pkt=%h",
                         i, txValid, txPacket, 34'h041000003);
            end
            tick();
        end
        total++;
        if (txPacket !== 34'h041000003) begin
            bad++;
            $display("[TB] FAIL stall_release: got %h expected %h", txPacket, 34'h041000003);
        end
        txReady = 1'b1;
        tick();
        total++;
        if (txPacket !== 34'h04200007F) begin
            bad++;
            $display("[TB] FAIL stall_psum_pkt: got %h expected %h", txPacket, 34'h04200007F);
        end
        tick();
        tick();
        // Wrong source with the psum op: must be dropped with a pulse.
        rxValid  = 1'b1;
        rxPacket = 34'h00A000011;
        tick();
        total++;
        if ({errDrop, rxReady, resValid} !== 3'b110) begin
            bad++;
            $display("[TB] FAIL drop_wrong_src: got drop,rx_ready,res_valid=%b expected %b",
                     {errDrop, rxReady, resValid}, 3'b110);
        end
        rxPacket = 34'h007000000;
        tick();
        total++;
        if ({errDrop, rxReady, resValid} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL drop_done_silent: got drop,rx_ready,res_valid=%b expected %b",
                     {errDrop, rxReady, resValid}, 3'b010);
        end
        rxPacket = 34'h006000042;
        tick();
        rxValid = 1'b0;
        total++;
        if ({resValid, resPsum, errDrop} !== {1'b1, 8'h42, 1'b0}) begin
            bad++;
            $display("[TB] FAIL drop_then_result: got valid=%b psum=%h drop=%b expected valid=1 psum=42 drop=0",
                     resValid, resPsum, errDrop);
        end
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
    endtask

    task automatic test_timeout();
        txReady = 1'b1;
        start_job(24'h555555, 5'h01, 8'h01);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({rxReady, errTimeout, resValid} !== 3'b100) begin
                bad++;
                $display("[TB] FAIL timeout_wait%0d: got rx_ready,timeout,res_valid=%b expected %b",
                         i, {rxReady, errTimeout, resValid}, 3'b100);
            end
            tick();
        end
        total++;
        if ({errTimeout, jobReady, resValid, busy} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL timeout_pulse: got timeout,job_ready,res_valid,busy=%b expected %b",
                     {errTimeout, jobReady, resValid, busy}, 4'b1100);
        end
        tick();
        total++;
        if ({errTimeout, resValid} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL timeout_one_cycle: got %b expected %b", {errTimeout, resValid}, 2'b00);
        end
    endtask

    task automatic test_result_beats_timeout();
        // Same filter as the timed-out job: the filter must be sent again.
        txReady = 1'b1;
        start_job(24'h555555, 5'h02, 8'h02);
        total++;
        if (txPacket !== 34'h040555555) begin
            bad++;
            $display("[TB] FAIL tie_filter_resent: got %h expected %h", txPacket, 34'h040555555);
        end
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 7; i++) tick();
        rxValid  = 1'b1;
        rxPacket = 34'h006000099;
        tick();
        rxValid = 1'b0;
        total++;
        if ({resValid, resPsum, errTimeout} !== {1'b1, 8'h99, 1'b0}) begin
            bad++;
            $display("[TB] FAIL tie_result_wins: got valid=%b psum=%h timeout=%b expected valid=1 psum=99 timeout=0",
                     resValid, resPsum, errTimeout);
        end
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        txReady = 1'b1;
        start_job(24'hAAAAAA, 5'h1F, 8'hFF);
        tick();
        tick();
        total++;
        if (txPacket !== 34'h0420000FF) begin
            bad++;
            $display("[TB] FAIL midreset_in_send_p: got %h expected %h", txPacket, 34'h0420000FF);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({jobReady, busy, txValid, rxReady, resValid, errTimeout, errDrop, txPacket, resPsum} !==
            {7'b1000000, 34'h0, 8'h00}) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: got flags=%b pkt=%h psum=%h expected flags=1000000 pkt=0 psum=00",
                     {jobReady, busy, txValid, rxReady, resValid, errTimeout, errDrop}, txPacket, resPsum);
        end
        start_job(24'hAAAAAA, 5'h1F, 8'hFF);
        total++;
        if ({txValid, txPacket} !== {1'b1, 34'h040AAAAAA}) begin
            bad++;
            $display("[TB] FAIL midreset_restart: got valid=%b pkt=%h expected valid=1 pkt=%h",
                     txValid, txPacket, 34'h040AAAAAA);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_filter_reuse();
        int pktCount;
        int expCount;
        logic [33:0] firstPkt;
        logic [33:0] expFirst;
`ifdef FILTER_REUSE_EN
        expCount = 3;
        expFirst = 34'h041000001;
`else
        expCount = 4;
        expFirst = 34'h040123456;
`endif
        txReady = 1'b1;
        start_job(24'h123456, 5'h01, 8'h02);
        for (int i = 0; i < 4; i++) tick();
        rxValid  = 1'b1;
        rxPacket = 34'h006000011;
        tick();
        rxValid  = 1'b0;
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
        start_job(24'h123456, 5'h01, 8'h02);
        firstPkt = txPacket;
        pktCount = 0;
        for (int i = 0; i < 10 && !rxReady; i++) begin
            if (txValid) pktCount++;
            tick();
        end
        total++;
        if (firstPkt !== expFirst) begin
            bad++;
            $display("[TB] FAIL reuse_first_pkt: got %h expected %h", firstPkt, expFirst);
        end
        total++;
        if (rxReady !== 1'b1 || pktCount != expCount) begin
            bad++;
            $display("[TB] FAIL reuse_pkt_count: got %0d (rx_ready=%b) expected %0d (rx_ready=1)",
                     pktCount, rxReady, expCount);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        jobValid  = 1'b0;
        jobFilter = '0;
        jobSpike  = '0;
        jobPsum   = '0;
        txReady   = 1'b0;
        rxValid   = 1'b0;
        rxPacket  = '0;
        resReady  = 1'b0;
        test_reset();
        test_basic_job();
        test_stall_and_drop();
        test_timeout();
        test_result_beats_timeout();
        test_reset_mid_job();
        test_filter_reuse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pe_job_dispatcher.md
# pe_job_dispatcher

Host-side initiator for one processing-element node on the NoC. It accepts a convolution job (filter frame, spike frame, partial sum), serialises it into filter, spike, psum and start packets addressed to its PE, then waits for the PE's psum result packet and returns the result to the host. It is the transmitting and collecting end of the PE packet protocol, and it sits between the layer controller and the router port that faces the PE.

## Interface
- PE_IDX, 1: destination address of the served PE.
- SELF_ADDR, 0: source address placed in outgoing packets.
- ADDR_WIDTH, 4: address field width.
- OP_WIDTH, 2: operation field width.
- DATA_WIDTH, 24: data field width (one filter frame).
- PACKET_WIDTH, 34: total packet width.
  - Layout is {dest[33:30], src[29:26], op[25:24], data[23:0]}.
- SPIKE_WIDTH, 5: spike frame width.
- PSUM_WIDTH, 8: psum width.
- TIMEOUT_CYCLES, 255: WAIT_RES cycle limit.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- job_valid  in  1  job offered.
- job_ready  out  1  dispatcher idle and accepting a job.
- job_filter  in  24  filter frame.
- job_spike  in  5  spike frame.
- job_psum  in  8  incoming partial sum.
- tx_valid  out  1  packet offered to the router.
- tx_ready  in  1  router accepts.
- tx_packet  out  34  outgoing packet.
- rx_valid  in  1  packet from the router.
- rx_ready  out  1  dispatcher accepts the packet.
- rx_packet  in  34  incoming packet.
- res_valid  out  1  result available.
- res_ready  in  1  host consumes the result.
- res_psum  out  8  resulting psum.
- busy  out  1  state is not IDLE.
- err_timeout  out  1  one-cycle pulse when the result wait expires.
- err_drop  out  1  one-cycle pulse when an unexpected rx packet is discarded.

## Operation
- Tx op codes:
  - 00 filter, data = job_filter.
  - 01 spike, data = zero-extended job_spike.
  - 10 psum, data = zero-extended job_psum.
  - 11 start, data = 0.
- Every tx packet has dest=PE_IDX and src=SELF_ADDR.
- FSM states: IDLE, SEND_F, SEND_S, SEND_P, SEND_GO, WAIT_RES, HOLD_RES.
- IDLE:
  - job_ready=1.
  - On job_valid, register all job fields and go to SEND_F.
- SEND_x states:
  - tx_valid=1 with that state's packet.
  - On tx_ready, advance SEND_F → SEND_S → SEND_P → SEND_GO → WAIT_RES.
- WAIT_RES:
  - rx_ready=1.
  - Result packet is src=PE_IDX and op=10: capture data[7:0] into res_psum, go to HOLD_RES.
  - Any other rx packet (wrong src, or op≠10) is consumed and discarded, with an err_drop pulse. Op 11 (PE done) is discarded silently, with no err_drop.
  - The timeout counter increments each cycle. When it reaches TIMEOUT_CYCLES: pulse err_timeout, go to IDLE, produce no result.
- HOLD_RES:
  - res_valid=1.
  - On res_ready, go to IDLE.
- rx_ready=0 in every state except WAIT_RES. The router is back-pressured, never dropped.

## Timing
- Reset values: state IDLE, job_ready=1, busy=0, tx_valid=0, tx_packet=0, rx_ready=0, res_valid=0, res_psum=0, err_timeout=0, err_drop=0, timeout counter=0.
- Reset mid-operation:
  - Aborts immediately; the next cycle is IDLE.
  - A partially sent job is not resumed.
- Job accepted at edge 0 → tx_valid=1 in cycle 1.
- With tx_ready held at 1, the four packets transfer in cycles 1–4 and WAIT_RES begins in cycle 5.
- tx_packet and tx_valid are stable while tx_valid && !tx_ready.
- A result accepted at edge N → res_valid=1 in cycle N+1.
- res_valid and res_psum are held stable until res_ready. With res_ready=1 in the same cycle, job_ready is high in cycle N+2.
- The timeout counter clears on entering WAIT_RES.
- A valid result and the timeout arriving in the same cycle: the result wins and no err_timeout is raised.
- err_timeout and err_drop are registered outputs, high for exactly one cycle.

## Configuration
- FILTER_REUSE_EN defined:
  - A last-filter register and a valid bit are kept.
  - If job_filter equals the last filter actually transferred and the bit is valid, SEND_F is skipped and IDLE → SEND_S.
  - The valid bit is cleared on reset and on timeout.
- FILTER_REUSE_EN undefined: every job sends all four packets.

## Test plan
- Send job filter=24'h030201, spike=5'b10110, psum=8'h05 with tx_ready=1. Required tx_packet sequence:
  - 34'h{1,0,0,030201}
  - then spike data 000016
  - then psum data 000005
  - then start
  - Then respond with rx src=1, op=10, data=8'h0C → res_psum=8'h0C in the following cycle.
- Hold tx_ready=0 for 3 cycles during SEND_S → tx_packet unchanged and no state advance.
- In WAIT_RES, send rx src=2, op=10 → err_drop pulse, state stays WAIT_RES. Then the correct packet → result delivered.
- TIMEOUT_CYCLES=8, no rx → err_timeout pulse after 8 WAIT_RES cycles, then job_ready=1 and res_valid never asserted.
- Assert reset during SEND_P → next cycle all outputs at their reset values. A new job then restarts at SEND_F.
- With FILTER_REUSE_EN, run two jobs with the same filter → the second job emits only spike, psum and start packets.
